// File: rtl/image_spec_pkg.sv
// Shared types and constants for the image-spec transmit path and its receiver-side address math.
package image_spec_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} spec_tx_state_t;

  localparam int SPEC_BYTES = 4;
  localparam logic [31:0] IMG_BASE_ADDR = 32'h0800_0000;

endpackage

// File: rtl/image_spec_tx.sv
// Byte-serial sender of {n_colum, n_row}, MSB first; first byte one cycle after start.
// Valid/ready: a byte and its index hold while out_ready is low; optional forced gap between bytes.
module image_spec_tx
  import image_spec_pkg::*;
#(
  parameter int FIELD_W    = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [FIELD_W-1:0] n_colum_in,
  input  logic [FIELD_W-1:0] n_row_in,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err_zero_dim
);

  localparam int          NBYTES   = 2 * FIELD_W / 8;
  localparam logic [1:0]  IDX_LAST = 2'(NBYTES - 1);
  localparam logic [3:0]  GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  generate
    if (NBYTES > SPEC_BYTES || FIELD_W < 8 || (FIELD_W % 8) != 0 ||
        GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_check
      $error("image_spec_tx: FIELD_W must be 8 or 16 and GAP_CYCLES 0..15");
    end
  endgenerate

  spec_tx_state_t           state, state_nxt;
  logic [1:0]               idx;
  logic [3:0]               gap_cnt;
  logic [2*FIELD_W-1:0]     cap;
  logic                     err_q;
  logic                     dims_ok;

  assign dims_ok      = (n_colum_in != '0) && (n_row_in != '0);
  assign err_zero_dim = err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && dims_ok) state_nxt = SEND;
      SEND: begin
        if (out_ready) begin
          if (idx == IDX_LAST)     state_nxt = DONE;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = SEND;
        end
      end
      GAP:  if (gap_cnt == 4'd0) state_nxt = SEND;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SEND);
    busy      = (state == SEND) || (state == GAP);
    done      = (state == DONE);
    out_data  = 8'h00;
    if (state == SEND) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (idx == 2'(b)) out_data = cap[(NBYTES-1-b)*8 +: 8];
      end
    end
  end

  // Capture only in IDLE so mid-frame input changes and repeated starts cannot disturb the frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx     <= 2'd0;
      gap_cnt <= 4'd0;
      cap     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cap   <= {n_colum_in, n_row_in};
            idx   <= 2'd0;
            err_q <= !dims_ok;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx != IDX_LAST) idx <= idx + 2'd1;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP:     gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule
